// File: rtl/sprite_queue_pkg.sv
// Shared types and constants for the sprite draw queue.
package sprite_queue_pkg;

  localparam int unsigned SQ_ID_W    = 8;
  localparam int unsigned SQ_COORD_W = 16;
  localparam int unsigned SQ_SCALE_W = 8;

  localparam int unsigned PKT_BYTES = 6;
  localparam int unsigned IDX_W     = $clog2(PKT_BYTES);

  localparam logic [IDX_W-1:0] IDX_ID    = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_XH    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_XL    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_YH    = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_YL    = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_SCALE = IDX_W'(5);

  typedef struct packed {
    logic [SQ_ID_W-1:0]    id;
    logic [SQ_COORD_W-1:0] x;
    logic [SQ_COORD_W-1:0] y;
    logic [SQ_SCALE_W-1:0] scale;
  } sprite_entry_t;

endpackage

// File: rtl/sprite_packet_assembler.sv
// Assembles 6-byte sprite commands from the MCU byte stream into queue entries.
module sprite_packet_assembler
  import sprite_queue_pkg::*;
(
  input  logic          clock,
  input  logic          fb_resetting,
  input  logic          i_valid,
  input  logic [7:0]    i_data,
  input  logic          i_sof,
  input  logic          i_full,
  output logic          o_ready_c,
  output logic          o_entry_valid_c,
  output sprite_entry_t o_entry_c,
  output logic [7:0]    o_resync_count
);

  logic [IDX_W-1:0] r_byte_idx;
  logic [7:0]       r_id;
  logic [7:0]       r_xh;
  logic [7:0]       r_xl;
  logic [7:0]       r_yh;
  logic [7:0]       r_yl;
  logic [7:0]       r_resync;
  logic             w_accept;

  // Only the packet-completing byte is held off when the queue is full.
  always_comb begin
    o_ready_c       = !(i_full && (r_byte_idx == IDX_SCALE));
    w_accept        = i_valid && o_ready_c;
    o_entry_valid_c = w_accept && !i_sof && (r_byte_idx == IDX_SCALE);
    o_entry_c.id    = SQ_ID_W'(r_id);
    o_entry_c.x     = SQ_COORD_W'({r_xh, r_xl});
    o_entry_c.y     = SQ_COORD_W'({r_yh, r_yl});
    o_entry_c.scale = SQ_SCALE_W'(i_data);
  end

  // Byte index state machine, field capture and resync counting.
  always_ff @(posedge clock or posedge fb_resetting) begin
    if (fb_resetting) begin
      r_byte_idx <= IDX_ID;
      r_id       <= 8'd0;
      r_xh       <= 8'd0;
      r_xl       <= 8'd0;
      r_yh       <= 8'd0;
      r_yl       <= 8'd0;
      r_resync   <= 8'd0;
    end else if (w_accept) begin
      if (i_sof) begin
        if ((r_byte_idx != IDX_ID) && (r_resync != 8'hFF)) begin
          r_resync <= r_resync + 8'd1;
        end
        r_id       <= i_data;
        r_byte_idx <= IDX_XH;
      end else begin
        case (r_byte_idx)
          IDX_ID:    r_byte_idx <= IDX_ID;
          IDX_XH: begin
            r_xh       <= i_data;
            r_byte_idx <= IDX_XL;
          end
          IDX_XL: begin
            r_xl       <= i_data;
            r_byte_idx <= IDX_YH;
          end
          IDX_YH: begin
            r_yh       <= i_data;
            r_byte_idx <= IDX_YL;
          end
          IDX_YL: begin
            r_yl       <= i_data;
            r_byte_idx <= IDX_SCALE;
          end
          default:   r_byte_idx <= IDX_ID;
        endcase
      end
    end
  end

  assign o_resync_count = r_resync;

endmodule

// File: rtl/sprite_queue.sv
// Sprite draw queue: packet assembler feeding a first-word-fall-through FIFO.
module sprite_queue
  import sprite_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned ID_W    = SQ_ID_W,
  parameter int unsigned COORD_W = SQ_COORD_W,
  parameter int unsigned SCALE_W = SQ_SCALE_W
) (
  input  logic                       clock,
  input  logic                       fb_resetting,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  input  logic                       in_sof,
  output logic                       in_ready,
  input  logic                       sprite_queue_dequeue,
  output logic                       sprite_queue_is_empty,
  output logic [ID_W-1:0]            sprite_queue_sprite_id,
  output logic [COORD_W-1:0]         sprite_queue_sprite_x,
  output logic [COORD_W-1:0]         sprite_queue_sprite_y,
  output logic [SCALE_W-1:0]         sprite_queue_sprite_scale,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic [7:0]                 resync_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sprite_entry_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  sprite_entry_t    w_entry;
  sprite_entry_t    w_head;

  sprite_packet_assembler u_asm (
    .clock           (clock),
    .fb_resetting    (fb_resetting),
    .i_valid         (in_valid),
    .i_data          (in_data),
    .i_sof           (in_sof),
    .i_full          (w_full),
    .o_ready_c       (in_ready),
    .o_entry_valid_c (w_push),
    .o_entry_c       (w_entry),
    .o_resync_count  (resync_count)
  );

  // Occupancy flags, pop qualification and zero-gated head view.
  always_comb begin
    w_full  = (r_count == CNT_W'(DEPTH));
    w_empty = (r_count == CNT_W'(0));
    w_pop   = sprite_queue_dequeue && !w_empty;
    w_head  = r_mem[r_rd_ptr] & {$bits(sprite_entry_t){!w_empty}};
  end

  // Entry storage; contents are don't-care until covered by the count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy explicitly.
  always_ff @(posedge clock or posedge fb_resetting) begin
    if (fb_resetting) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign sprite_queue_is_empty     = w_empty;
  assign queue_count               = r_count;
  assign sprite_queue_sprite_id    = ID_W'(w_head.id);
  assign sprite_queue_sprite_x     = COORD_W'(w_head.x);
  assign sprite_queue_sprite_y     = COORD_W'(w_head.y);
  assign sprite_queue_sprite_scale = SCALE_W'(w_head.scale);

endmodule
